// File: rtl/rc_eval_pkg.sv
// Shared definitions for the adder error evaluator: the FSM state set and the
// widths derived from the operand width of the adder under evaluation.
package rc_eval_pkg;

    // Operand width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Exact sum of two w-bit operands, also the width of one absolute error.
    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    // Sum of 2^(2w) errors, each below 2^(w+1), fits in 3w+1 bits.
    function automatic int err_sum_w(input int w);
        return 3 * w + 1;
    endfunction

    // Count of erroneous pairs reaches 2^(2w), so it needs 2w+1 bits.
    function automatic int err_cnt_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage : rc_eval_pkg

// File: rtl/rc_err_eval_abs_err_calc.sv
// Combinational reference for one operand pair: forms the exact sum and the
// absolute difference against the response of the adder under evaluation.
module abs_err_calc
    import rc_eval_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [sum_w(WIDTH)-1:0] approx,
    output logic [sum_w(WIDTH)-1:0] abs_err
);

    localparam int SW = sum_w(WIDTH);

    logic [SW-1:0] exact;

    // Exact sum is one bit wider than the operands, so it never wraps; the
    // difference of two SW-bit unsigned values always fits back into SW bits
    // when the larger one is taken as the minuend.
    always_comb begin
        exact = {1'b0, a} + {1'b0, b};
        if (exact >= approx) begin
            abs_err = exact - approx;
        end else begin
            abs_err = approx - exact;
        end
    end

endmodule : abs_err_calc

// File: rtl/rc_err_eval.sv
// Exhaustive error evaluator for an external approximate adder. Presents every
// operand pair once, compares the adder's response with the exact sum, and
// accumulates total, maximum and count of nonzero absolute errors through a
// two-stage pipeline (register error, then accumulate).
module rc_err_eval
    import rc_eval_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic [WIDTH-1:0]            in1,
    output logic [WIDTH-1:0]            in2,
    input  logic [sum_w(WIDTH)-1:0]     approx_sum,
    output logic                        busy,
    output logic                        done,
    output logic [err_sum_w(WIDTH)-1:0] err_sum,
    output logic [sum_w(WIDTH)-1:0]     err_max,
    output logic [err_cnt_w(WIDTH)-1:0] err_cnt,
    output logic [sum_w(WIDTH)-1:0]     mae_int
);

    localparam int SW  = sum_w(WIDTH);
    localparam int ESW = err_sum_w(WIDTH);
    localparam int ECW = err_cnt_w(WIDTH);

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   in1_reg;
    logic [WIDTH-1:0]   in2_reg;

    logic [SW-1:0]      abs_err;
    logic [SW-1:0]      s1_err_reg;
    logic               s1_valid_reg;

    logic [ESW-1:0]     err_sum_reg;
    logic [SW-1:0]      err_max_reg;
    logic [ECW-1:0]     err_cnt_reg;

    logic               accept_start;
    logic               discard;
    logic               last_pair;
    logic               sweep_step;

    // The final pair is the one with both operands at their maximum value.
    assign last_pair  = (&in1_reg) & (&in2_reg);

    // A new pair is sampled on every SWEEP cycle that is not being aborted.
    assign sweep_step = (state_reg == ST_SWEEP) && !abort;

    abs_err_calc #(
        .WIDTH (WIDTH)
    ) u_abs_err_calc (
        .a       (in1_reg),
        .b       (in2_reg),
        .approx  (approx_sum),
        .abs_err (abs_err)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE/DONE, and abort
    // overrides everything while a sweep is in progress.
    always_comb begin
        state_next   = state_reg;
        accept_start = 1'b0;
        discard      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next   = ST_SWEEP;
                    accept_start = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    discard    = 1'b1;
                end else if (last_pair) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    discard    = 1'b1;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand counters: in2 is the fast digit, in1 advances when in2 wraps.
    // Both stop on the last pair and keep those values through DRAIN/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_reg <= '0;
            in2_reg <= '0;
        end else if (accept_start) begin
            in1_reg <= '0;
            in2_reg <= '0;
        end else if (sweep_step && !last_pair) begin
            in2_reg <= in2_reg + 1'b1;
            if (&in2_reg) begin
                in1_reg <= in1_reg + 1'b1;
            end
        end
    end

    // Stage 1: capture the error of the pair presented this cycle. Outside
    // SWEEP the register is emptied; its old content is still read by the
    // accumulators on that same edge, which is how DRAIN retires the last pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_err_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end else if (sweep_step) begin
            s1_err_reg   <= abs_err;
            s1_valid_reg <= 1'b1;
        end else begin
            s1_err_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 2: fold the registered error into the running statistics. An
    // abort drops the in-flight stage-1 result and freezes the accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum_reg <= '0;
            err_max_reg <= '0;
            err_cnt_reg <= '0;
        end else if (accept_start) begin
            err_sum_reg <= '0;
            err_max_reg <= '0;
            err_cnt_reg <= '0;
        end else if (s1_valid_reg && !discard) begin
            err_sum_reg <= err_sum_reg + ESW'(s1_err_reg);
            if (s1_err_reg > err_max_reg) begin
                err_max_reg <= s1_err_reg;
            end
            if (s1_err_reg != '0) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign in1     = in1_reg;
    assign in2     = in2_reg;
    assign busy    = (state_reg == ST_SWEEP) || (state_reg == ST_DRAIN);
    assign done    = (state_reg == ST_DONE);
    assign err_sum = err_sum_reg;
    assign err_max = err_max_reg;
    assign err_cnt = err_cnt_reg;
    // Dividing by the 2^(2*WIDTH) pair count is a plain shift.
    assign mae_int = err_sum_reg[ESW-1:2*WIDTH];

endmodule : rc_err_eval

// File: tb/tb_rc_err_eval.sv
// Bench for rc_err_eval at a reduced operand width so full sweeps stay short.
// The external adder is emulated by per-scenario lookup tables; expectations
// come from closed-form results or from a direct loop over all operand pairs.
module tb_rc_err_eval;

    localparam int W     = 4;
    localparam int NV    = 1 << W;        // values per operand
    localparam int NP    = NV * NV;       // pairs per sweep
    localparam int ROWS  = 6;
    localparam int NVEC  = 7;
    localparam int ABORT_AT = 100;
    localparam int RST_AT   = 60;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [W-1:0]     in1;
    logic [W-1:0]     in2;
    logic [W:0]       approx_sum;
    logic             busy;
    logic             done;
    logic [3*W:0]     err_sum;
    logic [W:0]       err_max;
    logic [2*W:0]     err_cnt;
    logic [W:0]       mae_int;

    logic [W:0]       lut [ROWS][NP];
    int               cur_row;

    int               vectors;
    int               miscompares;

    typedef struct {
        int     row;
        int     extra_start;     // >0: pulse start at this sweep cycle and in DRAIN
        longint exp_sum;
        longint exp_max;
        longint exp_cnt;
        longint exp_mae;
    } vec_t;

    vec_t tbl [NVEC];

    rc_err_eval #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in1        (in1),
        .in2        (in2),
        .approx_sum (approx_sum),
        .busy       (busy),
        .done       (done),
        .err_sum    (err_sum),
        .err_max    (err_max),
        .err_cnt    (err_cnt),
        .mae_int    (mae_int)
    );

    // Emulated adder under evaluation: a pure function of the operands.
    assign approx_sum = lut[cur_row][{in1, in2}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Statistics over the first np pairs of the sweep order, straight from
    // the definition of absolute error.
    function automatic void model(input int row, input int np,
                                  output longint s, output longint m, output longint c);
        s = 0; m = 0; c = 0;
        for (int p = 0; p < np; p++) begin
            int ex, ap, d;
            ex = (p / NV) + (p % NV);
            ap = int'(lut[row][p]);
            d  = (ex > ap) ? ex - ap : ap - ex;
            s += d;
            if (d > m) m = d;
            if (d != 0) c++;
        end
    endfunction

    // One complete sweep from an accepted start, checking pair order, busy,
    // latency, final results and that results stay put while done is high.
    task automatic run_sweep(input int idx, input bit abort_with_start);
        int cyc;
        int order_bad;
        int busy_bad;
        int exp_pair;
        logic [3*W:0] held_sum;
        cur_row = tbl[idx].row;
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc = 0;
        order_bad = ({in1, in2} !== 0) ? 1 : 0;
        busy_bad  = (busy !== 1'b1) ? 1 : 0;
        while (cyc < NP + 40) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done === 1'b1) break;
            exp_pair = (cyc < NP) ? cyc : NP - 1;
            if ({in1, in2} !== exp_pair[2*W-1:0]) order_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (tbl[idx].extra_start > 0 && (cyc == tbl[idx].extra_start || cyc == NP))
                start = 1'b1;
        end
        $display("sweep %0d row %0d: latency %0d sum %0d max %0d cnt %0d mae %0d",
                 idx, cur_row, cyc, err_sum, err_max, err_cnt, mae_int);
        check("latency",   cyc, NP + 1);
        check("order",     order_bad, 0);
        check("busy",      busy_bad, 0);
        check("err_sum",   err_sum, tbl[idx].exp_sum);
        check("err_max",   err_max, tbl[idx].exp_max);
        check("err_cnt",   err_cnt, tbl[idx].exp_cnt);
        check("mae_int",   mae_int, tbl[idx].exp_mae);
        check("final_ops", {in1, in2}, NP - 1);
        held_sum = err_sum;
        repeat (3) @(negedge clk);
        check("done_hold", {done, busy}, 2'b10);
        check("sum_hold",  err_sum, held_sum);
    endtask

    initial begin
        longint s, m, c;
        int cyc;
        logic [3*W:0] held;

        vectors     = 0;
        miscompares = 0;
        cur_row     = 0;
        start       = 1'b0;
        abort       = 1'b0;
        rst         = 1'b1;

        // Adder models: exact, stuck at zero, off by one, random response,
        // truncated LSB, and exact with small random noise.
        for (int p = 0; p < NP; p++) begin
            int ex, nz;
            ex = (p / NV) + (p % NV);
            lut[0][p] = (W+1)'(ex);
            lut[1][p] = '0;
            lut[2][p] = (W+1)'(ex + 1);
            lut[3][p] = (W+1)'($urandom_range(0, 2 * NV - 1));
            lut[4][p] = (W+1)'(ex & ~1);
            nz = ex + int'($urandom_range(0, 4)) - 2;
            if (nz < 0) nz = 0;
            if (nz > 2 * NV - 1) nz = 2 * NV - 1;
            lut[5][p] = (W+1)'(nz);
        end

        tbl[0] = '{0, 0, 0, 0, 0, 0};
        s = 2 * NV * (NV * (NV - 1) / 2);
        tbl[1] = '{1, 0, s, 2 * (NV - 1), NP - 1, s >> (2 * W)};
        tbl[2] = '{2, 0, NP, 1, NP, 1};
        for (int r = 3; r <= 5; r++) begin
            model(r, NP, s, m, c);
            tbl[r] = '{r, 0, s, m, c, s >> (2 * W)};
        end
        model(3, NP, s, m, c);
        tbl[6] = '{3, 40, s, m, c, s >> (2 * W)};

        // Reset state.
        #2;
        check("rst_out", {in1, in2, busy, done, err_sum, err_max, err_cnt, mae_int}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst", {busy, done}, 0);

        // Table-driven full sweeps, back to back (later starts come from DONE).
        for (int i = 0; i < NVEC; i++) begin
            run_sweep(i, 1'b0);
        end

        // Abort mid-sweep: in-flight result dropped, accumulators frozen.
        cur_row = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < ABORT_AT) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        model(3, ABORT_AT - 1, s, m, c);
        $display("abort at %0d: busy %0b done %0b sum %0d max %0d cnt %0d",
                 ABORT_AT, busy, done, err_sum, err_max, err_cnt);
        check("abort_state", {busy, done}, 2'b00);
        check("abort_sum",   err_sum, s);
        check("abort_max",   err_max, m);
        check("abort_cnt",   err_cnt, c);
        held = err_sum;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check("idle_hold", {busy, done, err_sum}, {2'b00, held});

        // Start and abort together in IDLE: start wins, exact adder gives zero.
        run_sweep(0, 1'b1);

        // Asynchronous reset between edges in the middle of a sweep.
        cur_row = 5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (RST_AT) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("rst mid-sweep: busy %0b done %0b in %0d/%0d sum %0d",
                 busy, done, in1, in2, err_sum);
        check("rst_mid", {in1, in2, busy, done, err_sum, err_max, err_cnt, mae_int}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_resume", {busy, done, in1, in2}, 0);

        // A fresh start after reset still runs a full, correct sweep.
        run_sweep(5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rc_err_eval

// File: doc/rc_err_eval.md
RC_ERR_EVAL -- requirements
Module: rc_err_eval

Interface
REQ-001 Parameter: WIDTH, default 8, operand width of the adder under evaluation; all derived widths below scale with it.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  one-cycle request to begin an exhaustive sweep; honoured only in IDLE or DONE.
REQ-005 Port: abort  input  1  terminates a running sweep; returns to IDLE.
REQ-006 Port: in1  output  WIDTH  registered operand A driven to the external adder.
REQ-007 Port: in2  output  WIDTH  registered operand B driven to the external adder.
REQ-008 Port: approx_sum  input  WIDTH+1  combinational response of the external adder to in1/in2, valid in the same cycle.
REQ-009 Port: busy  output  1  high in SWEEP and DRAIN.
REQ-010 Port: done  output  1  high in DONE; results stable while high.
REQ-011 Port: err_sum  output  3*WIDTH+1  accumulated absolute error over all operand pairs.
REQ-012 Port: err_max  output  WIDTH+1  largest absolute error seen.
REQ-013 Port: err_cnt  output  2*WIDTH+1  number of pairs with nonzero error.
REQ-014 Port: mae_int  output  WIDTH+1  integer mean absolute error, err_sum >> 2*WIDTH.

Function
REQ-015 FSM states IDLE, SWEEP, DRAIN, DONE; transitions: IDLE/DONE -start-> SWEEP; SWEEP -last pair sampled-> DRAIN; DRAIN -> DONE after one cycle; SWEEP/DRAIN -abort-> IDLE.
REQ-016 On accepted start: in1=0, in2=0, err_sum/err_max/err_cnt cleared, next state SWEEP.
REQ-017 Sweep order: in2 increments every SWEEP cycle, in1 increments when in2 wraps from 2^WIDTH-1 to 0; exactly 2^(2*WIDTH) pairs, each presented for one cycle.
REQ-018 Each SWEEP cycle: exact = in1 + in2 at WIDTH+1 bits; abs_err = |exact - approx_sum| as unsigned WIDTH+1 bits; abs_err registered (stage 1).
REQ-019 Stage 2 (one cycle later): err_sum += abs_err; err_max = max(err_max, abs_err); err_cnt += (abs_err != 0).
REQ-020 DRAIN exists solely to accumulate the final pair's stage-1 result; no new pair presented in DRAIN.
REQ-021 Total latency start-accepted to done-high: 2^(2*WIDTH)+1 cycles (65537 for WIDTH=8).
REQ-022 Accumulators never overflow by construction of widths; no saturation logic.
REQ-023 start while busy ignored; start and abort in the same cycle: abort wins when busy, start wins in IDLE/DONE.
REQ-024 abort: stage-1 result discarded, accumulators hold last values, done low.
REQ-025 in1/in2 hold their final values (2^WIDTH-1) in DRAIN and DONE.

Reset
REQ-026 rst asserted: state IDLE, in1=0, in2=0, busy=0, done=0, err_sum=0, err_max=0, err_cnt=0, stage-1 register=0, immediately and independent of clk.
REQ-027 rst mid-sweep: sweep lost; a new start is required after deassertion.

Structure
REQ-028 Shared package rc_eval_pkg holds the FSM state enum and the derived-width constants (sum, err_sum, err_cnt widths as functions of WIDTH).
REQ-029 One sub-module abs_err_calc (combinational exact-sum and absolute-difference) is natural; FSM, counters and accumulators stay in rc_err_eval.
REQ-030 The adder under test is external; rc_err_eval instantiates no adder.

Verification
REQ-031 Exact adder attached, start -> done after 65537 cycles, err_sum=0, err_max=0, err_cnt=0, mae_int=0.
REQ-032 approx_sum tied to 0 -> err_sum=16711680, err_max=510, err_cnt=65535, mae_int=255.
REQ-033 approx_sum = exact+1 -> err_sum=65536, err_max=1, err_cnt=65536, mae_int=1.
REQ-034 abort at sweep cycle 1000 -> IDLE next cycle, busy=0, done=0; subsequent start reproduces REQ-031 results exactly.
REQ-035 rst pulsed mid-sweep (between edges) -> all outputs zero immediately; start pulses while busy produce no restart (done timing unchanged).
